// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, prefetches {pc, instr} pairs from a
// combinational instruction memory into a small FIFO and hands them to decode.
module ifetch_ctrl #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            halt_req,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            halted
);

  // state  | meaning
  // IDLE   | out of reset, no fetching until start
  // RUN    | fetching one word per cycle while the FIFO has room
  // HALT   | fetching stopped, FIFO drains, start resumes at pc
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [1:0]      state, state_nxt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] fifo_pc    [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_instr [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic            empty, full, push, pop;

  // Redirect targets are word-aligned; the low bits are intentionally dropped.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign empty = (count == '0);
  assign full  = (count == CW'(FIFO_DEPTH));
  assign pop   = !empty && out_ready;
  assign push  = (state == S_RUN) && !halt_req && !redirect_valid && (!full || pop);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (halt_req) state_nxt = S_HALT;
      S_HALT:  if (start) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Redirect overrides everything: flush, drop any concurrent pop, reload pc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      pc     <= {redirect_pc[XLEN-1:2], 2'b00};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc     <= pc + XLEN'(4);
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= pc;
      fifo_instr[wr_ptr] <= imem_rdata;
    end
  end

  assign imem_addr = pc;
  assign out_valid = !empty;
  assign out_pc    = empty ? '0 : fifo_pc[rd_ptr];
  assign out_instr = empty ? '0 : fifo_instr[rd_ptr];
  assign halted    = (state == S_HALT) && empty;

endmodule
